token_decoder: RTL and testbench

Inverse of the vocabulary encoder: walks a RAM of token IDs, expands each token into its byte string from the vocabulary RAM, and writes the reconstructed bytes sequentially into an output RAM. Sits beside the encoder and drives three single-port synchronous `sram` instances (token, vocab, output) through its own address/data ports. Runs one job per `cs` request and reports completion and errors.

---
 rtl/token_decoder.sv | 183 ++++++++++++++++++
 tb/tb_token_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/token_decoder.sv
// Expands a stream of token IDs into their vocabulary byte strings, writing the bytes to an output RAM.
// Optional build macro TOKEN_DECODER_SEP_EN inserts SEP_BYTE between decoded tokens.
module token_decoder #(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ENTRY_LEN  = 4,
    parameter logic [DATA_WIDTH-1:0] SEP_BYTE   = 8'h20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   out_len,
    output logic [ADDR_WIDTH-1:0] tok_addr,
    input  logic [DATA_WIDTH-1:0] tok_dout,
    output logic [ADDR_WIDTH-1:0] voc_addr,
    input  logic [DATA_WIDTH-1:0] voc_dout,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_din,
    output logic                  out_we
);

    localparam int DEPTH       = 2 ** ADDR_WIDTH;
    localparam int NUM_ENTRIES = DEPTH / ENTRY_LEN;
    localparam int OFF_W       = $clog2(ENTRY_LEN) + 1;

    typedef enum logic [2:0] {
        IDLE, TOK_RD, TOK_DATA, VOC_RD, VOC_DATA, DONE
`ifdef TOKEN_DECODER_SEP_EN
        , SEP
`endif
    } state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   tp_reg;
    logic [ADDR_WIDTH-1:0]   tok_base_reg;
    logic [OFF_W-1:0]        offset_reg;
    logic [ADDR_WIDTH:0]     out_len_reg;
    logic                    err_reg;
    logic                    done_reg;
    logic [ADDR_WIDTH-1:0]   tok_addr_reg;
    logic [ADDR_WIDTH-1:0]   voc_addr_reg;
    logic [ADDR_WIDTH-1:0]   out_addr_reg;
    logic [DATA_WIDTH-1:0]   out_din_reg;
    logic                    out_we_reg;

    logic                    tok_eos;
    logic                    tok_bad;
    logic [ADDR_WIDTH-1:0]   tok_base_next;
    logic [OFF_W-1:0]        offset_next;
    logic [ADDR_WIDTH-1:0]   tp_next;
    logic                    out_full;
    logic                    last_tok;

    assign tok_eos       = &tok_dout;
    assign tok_bad       = {1'b0, tok_dout} >= (DATA_WIDTH+1)'(NUM_ENTRIES);
    assign tok_base_next = ADDR_WIDTH'(tok_dout) * ADDR_WIDTH'(ENTRY_LEN);
    assign offset_next   = offset_reg + OFF_W'(1);
    assign tp_next       = tp_reg + ADDR_WIDTH'(1);
    assign out_full      = out_len_reg[ADDR_WIDTH];
    assign last_tok      = &tp_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            tp_reg       <= '0;
            tok_base_reg <= '0;
            offset_reg   <= '0;
            out_len_reg  <= '0;
            err_reg      <= 1'b0;
            done_reg     <= 1'b0;
            tok_addr_reg <= '0;
            voc_addr_reg <= '0;
            out_addr_reg <= '0;
            out_din_reg  <= '0;
            out_we_reg   <= 1'b0;
        end else begin
            out_we_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cs) begin
                        tp_reg       <= '0;
                        offset_reg   <= '0;
                        out_len_reg  <= '0;
                        err_reg      <= 1'b0;
                        tok_addr_reg <= '0;
                        state_reg    <= TOK_RD;
                    end
                end
                TOK_RD: state_reg <= TOK_DATA;
                TOK_DATA: begin
                    if (tok_eos) begin
                        state_reg <= DONE;
                    end else if (tok_bad) begin
                        err_reg <= 1'b1;
                        if (last_tok) begin
                            state_reg <= DONE;
                        end else begin
                            tp_reg       <= tp_next;
                            tok_addr_reg <= tp_next;
                            state_reg    <= TOK_RD;
                        end
                    end else begin
                        tok_base_reg <= tok_base_next;
                        offset_reg   <= '0;
                        voc_addr_reg <= tok_base_next;
`ifdef TOKEN_DECODER_SEP_EN
                        state_reg    <= (out_len_reg != '0) ? SEP : VOC_RD;
`else
                        state_reg    <= VOC_RD;
`endif
                    end
                end
                VOC_RD: state_reg <= VOC_DATA;
                VOC_DATA: begin
                    if (voc_dout != '0 && out_full) begin
                        err_reg   <= 1'b1;
                        state_reg <= DONE;
                    end else if (voc_dout != '0 && offset_next != OFF_W'(ENTRY_LEN)) begin
                        out_we_reg   <= 1'b1;
                        out_addr_reg <= out_len_reg[ADDR_WIDTH-1:0];
                        out_din_reg  <= voc_dout;
                        out_len_reg  <= out_len_reg + (ADDR_WIDTH+1)'(1);
                        offset_reg   <= offset_next;
                        voc_addr_reg <= tok_base_reg + ADDR_WIDTH'(offset_next);
                        state_reg    <= VOC_RD;
                    end else begin
                        // Entry finished: either a 0x00 terminator or the last byte of a full slot.
                        if (voc_dout != '0) begin
                            out_we_reg   <= 1'b1;
                            out_addr_reg <= out_len_reg[ADDR_WIDTH-1:0];
                            out_din_reg  <= voc_dout;
                            out_len_reg  <= out_len_reg + (ADDR_WIDTH+1)'(1);
                            offset_reg   <= offset_next;
                        end
                        if (last_tok) begin
                            state_reg <= DONE;
                        end else begin
                            tp_reg       <= tp_next;
                            tok_addr_reg <= tp_next;
                            state_reg    <= TOK_RD;
                        end
                    end
                end
`ifdef TOKEN_DECODER_SEP_EN
                SEP: begin
                    if (out_full) begin
                        err_reg   <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        out_we_reg   <= 1'b1;
                        out_addr_reg <= out_len_reg[ADDR_WIDTH-1:0];
                        out_din_reg  <= SEP_BYTE;
                        out_len_reg  <= out_len_reg + (ADDR_WIDTH+1)'(1);
                        state_reg    <= VOC_RD;
                    end
                end
`endif
                DONE: begin
                    // done rises on the first DONE cycle; only then is cs=0 accepted as the release.
                    if (!done_reg) begin
                        done_reg <= 1'b1;
                    end else if (!cs) begin
                        done_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign done     = done_reg;
    assign err      = err_reg;
    assign out_len  = out_len_reg;
    assign tok_addr = tok_addr_reg;
    assign voc_addr = voc_addr_reg;
    assign out_addr = out_addr_reg;
    assign out_din  = out_din_reg;
    assign out_we   = out_we_reg;

endmodule

// File: tb/tb_token_decoder.sv
// Directed bench for token_decoder with behavioural token/vocab/output RAMs.
module tb_token_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b0;
    logic       done;
    logic       err;
    logic [4:0] out_len;
    logic [3:0] tok_addr;
    logic [7:0] tok_dout;
    logic [3:0] voc_addr;
    logic [7:0] voc_dout;
    logic [3:0] out_addr;
    logic [7:0] out_din;
    logic       out_we;

    logic [7:0] tok_mem [16];
    logic [7:0] voc_mem [16];
    logic [7:0] out_mem [16];
    logic [7:0] exp_bytes [16];
    int         wr_count = 0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    token_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (cs),
        .done     (done),
        .err      (err),
        .out_len  (out_len),
        .tok_addr (tok_addr),
        .tok_dout (tok_dout),
        .voc_addr (voc_addr),
        .voc_dout (voc_dout),
        .out_addr (out_addr),
        .out_din  (out_din),
        .out_we   (out_we)
    );

    always @(posedge clk) begin
        tok_dout <= tok_mem[tok_addr];
        voc_dout <= voc_mem[voc_addr];
        if (out_we) begin
            out_mem[out_addr] = out_din;
            wr_count = wr_count + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic load_tokens(input logic [7:0] t0, input logic [7:0] t1,
                               input logic [7:0] t2, input logic [7:0] t3);
        for (int i = 0; i < 16; i++) tok_mem[i] = 8'hFF;
        tok_mem[0] = t0; tok_mem[1] = t1; tok_mem[2] = t2; tok_mem[3] = t3;
        for (int i = 0; i < 16; i++) out_mem[i] = 8'hEE;
    endtask

    // Starts a job and returns the index (1 = sampling edge) of the edge after which done is seen.
    task automatic run_job(input string tag, output int lat);
        lat = -1;
        @(negedge clk);
        cs = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        check_eq({tag, "_done"}, done, 1);
    endtask

    task automatic check_result(input string tag, input int exp_len, input logic exp_err, input int wr_before);
        check_eq({tag, "_out_len"}, out_len, exp_len);
        check_eq({tag, "_err"}, err, exp_err);
        check_eq({tag, "_writes"}, wr_count - wr_before, exp_len);
        for (int i = 0; i < exp_len; i++)
            check_eq($sformatf("%s_byte%0d", tag, i), out_mem[i], exp_bytes[i]);
    endtask

    task automatic end_job(input string tag);
        int w;
        w = wr_count;
        repeat (4) @(posedge clk);
        #1;
        check_eq({tag, "_done_held"}, done, 1);
        check_eq({tag, "_no_restart"}, wr_count - w, 0);
        @(negedge clk);
        cs = 1'b0;
        for (int k = 0; k < 10 && done; k++) begin
            @(posedge clk);
            #1;
        end
        check_eq({tag, "_done_release"}, done, 0);
    endtask

    task automatic set_exp_t1();
`ifdef TOKEN_DECODER_SEP_EN
        exp_bytes = '{8'h63, 8'h64, 8'h65, 8'h66, 8'h20, 8'h61, 8'h62, 8'h20,
                      8'h67, 0, 0, 0, 0, 0, 0, 0};
`else
        exp_bytes = '{8'h63, 8'h64, 8'h65, 8'h66, 8'h61, 8'h62, 8'h67, 0,
                      0, 0, 0, 0, 0, 0, 0, 0};
`endif
    endtask

    initial begin
        int lat;
        int w;
        int t1_len;
`ifdef TOKEN_DECODER_SEP_EN
        t1_len = 9;
`else
        t1_len = 7;
`endif
        voc_mem = '{8'h61, 8'h62, 8'h00, 8'h00, 8'h63, 8'h64, 8'h65, 8'h66,
                    8'h67, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_tokens(8'hFF, 8'hFF, 8'hFF, 8'hFF);

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_out_len", out_len, 0);
        check_eq("rst_out_we", out_we, 0);
        check_eq("rst_addrs", {tok_addr, voc_addr, out_addr}, 0);
        check_eq("rst_out_din", out_din, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic decode.
        load_tokens(8'h01, 8'h00, 8'h02, 8'hFF);
        set_exp_t1();
        w = wr_count;
        run_job("t1", lat);
        check_result("t1", t1_len, 1'b0, w);
        end_job("t1");

        // Leading end-of-stream.
        load_tokens(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        w = wr_count;
        run_job("eos", lat);
        check_eq("eos_latency", lat, 4);
        check_eq("eos_out_len", out_len, 0);
        check_eq("eos_writes", wr_count - w, 0);
        end_job("eos");

        // Out-of-range token is skipped and flagged.
        load_tokens(8'h00, 8'h07, 8'h01, 8'hFF);
`ifdef TOKEN_DECODER_SEP_EN
        exp_bytes = '{8'h61, 8'h62, 8'h20, 8'h63, 8'h64, 8'h65, 8'h66, 0,
                      0, 0, 0, 0, 0, 0, 0, 0};
        w = wr_count;
        run_job("bad", lat);
        check_result("bad", 7, 1'b1, w);
`else
        exp_bytes = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 0, 0,
                      0, 0, 0, 0, 0, 0, 0, 0};
        w = wr_count;
        run_job("bad", lat);
        check_result("bad", 6, 1'b1, w);
`endif
        end_job("bad");

        // No terminator: output RAM overflows.
        load_tokens(8'h01, 8'h01, 8'h01, 8'h01);
        for (int i = 0; i < 16; i++) tok_mem[i] = 8'h01;
`ifdef TOKEN_DECODER_SEP_EN
        exp_bytes = '{8'h63, 8'h64, 8'h65, 8'h66, 8'h20, 8'h63, 8'h64, 8'h65,
                      8'h66, 8'h20, 8'h63, 8'h64, 8'h65, 8'h66, 8'h20, 8'h63};
`else
        exp_bytes = '{8'h63, 8'h64, 8'h65, 8'h66, 8'h63, 8'h64, 8'h65, 8'h66,
                      8'h63, 8'h64, 8'h65, 8'h66, 8'h63, 8'h64, 8'h65, 8'h66};
`endif
        w = wr_count;
        run_job("ovf", lat);
        check_result("ovf", 16, 1'b1, w);
        end_job("ovf");

        // Reset in the middle of a job drops the pending write.
        load_tokens(8'h01, 8'h00, 8'h02, 8'hFF);
        @(negedge clk);
        cs = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (out_we) break;
        end
        check_eq("mid_we_seen", out_we, 1);
        w = wr_count;
        rst_n = 1'b0;
        cs = 1'b0;
        #1;
        check_eq("mid_rst_out_we", out_we, 0);
        check_eq("mid_rst_out_len", out_len, 0);
        check_eq("mid_rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("mid_rst_dropped", wr_count - w, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("mid_idle_no_write", wr_count - w, 0);

        load_tokens(8'h01, 8'h00, 8'h02, 8'hFF);
        set_exp_t1();
        w = wr_count;
        run_job("rerun", lat);
        check_result("rerun", t1_len, 1'b0, w);
        end_job("rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
